// File: rtl/flush_ctrl.sv
// rtl/flush_ctrl.sv - exception/ertn flush sequencer
// Squashes the pipeline and drains in-flight fetch responses before redirecting IF.
module flush_ctrl #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_ex,
  input  logic        wb_ertn,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  input  logic        inst_req_fire,
  input  logic        inst_resp_fire,
  input  logic        redirect_ack,
  output logic        flush,
  output logic        fetch_stall,
  output logic        resp_discard,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_REDIR = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   pc_q, pc_d;
  logic          trig;

  // A response with nothing outstanding and no matching request is spurious and dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (inst_req_fire && !inst_resp_fire) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!inst_req_fire && inst_resp_fire && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Reset gating keeps flush low while resetn is held, even if WB still shows a retire.
  assign trig = resetn & (wb_ex | wb_ertn) & (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        flush = trig;
        if (trig) begin
          pc_d    = wb_ex ? csr_eentry : csr_era;
          state_d = (cnt_d != '0) ? S_DRAIN : S_REDIR;
        end
      end
      S_DRAIN: begin
        if (cnt_d == '0) begin
          state_d = S_REDIR;
        end
      end
      S_REDIR: begin
        if (redirect_ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pc_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  assign fetch_stall    = (state_q == S_DRAIN) | (state_q == S_REDIR) | (cnt_q == CNT_MAX);
  assign resp_discard   = (state_q == S_DRAIN);
  assign redirect_valid = (state_q == S_REDIR);
  assign redirect_pc    = pc_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_flush_ctrl.sv
// tb/tb_flush_ctrl.sv - self-checking bench for flush_ctrl
// Model tracks outstanding count, busy flag and latched target; compared every negedge.
module tb_flush_ctrl;
  localparam int MAXO = 2;

  logic        clk;
  logic        resetn;
  logic        wb_ex, wb_ertn;
  logic [31:0] csr_eentry, csr_era;
  logic        inst_req_fire, inst_resp_fire, redirect_ack;
  logic        flush, fetch_stall, resp_discard, redirect_valid, busy;
  logic [31:0] redirect_pc;

  int n_pass;
  int n_total;

  int          m_cnt;
  bit          m_busy;
  logic [31:0] m_pc;

  flush_ctrl #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .wb_ex         (wb_ex),
    .wb_ertn       (wb_ertn),
    .csr_eentry    (csr_eentry),
    .csr_era       (csr_era),
    .inst_req_fire (inst_req_fire),
    .inst_resp_fire(inst_resp_fire),
    .redirect_ack  (redirect_ack),
    .flush         (flush),
    .fetch_stall   (fetch_stall),
    .resp_discard  (resp_discard),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // While busy, an empty bus means the redirect is being offered; otherwise responses are dropped.
  always @(negedge clk) begin
    bit trig;
    bit dec;
    if (!resetn) begin
      m_cnt  = 0;
      m_busy = 1'b0;
      m_pc   = 32'h0;
    end
    trig = resetn && !m_busy && (wb_ex || wb_ertn);
    chk("m_flush",     flush,          32'(trig));
    chk("m_stall",     fetch_stall,    32'(m_busy || (m_cnt == MAXO)));
    chk("m_discard",   resp_discard,   32'(m_busy && (m_cnt > 0)));
    chk("m_rvalid",    redirect_valid, 32'(m_busy && (m_cnt == 0)));
    chk("m_rpc",       redirect_pc,    m_pc);
    chk("m_busy",      busy,           32'(m_busy));
    if (resetn) begin
      dec = inst_resp_fire && (m_cnt > 0 || inst_req_fire);
      if (trig) begin
        m_busy = 1'b1;
        m_pc   = wb_ex ? csr_eentry : csr_era;
      end else if (m_busy && m_cnt == 0 && redirect_ack) begin
        m_busy = 1'b0;
      end
      m_cnt = m_cnt + int'(inst_req_fire) - int'(dec);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
    wb_ex = 0; wb_ertn = 0; inst_req_fire = 0; inst_resp_fire = 0; redirect_ack = 0;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    resetn = 0; wb_ex = 0; wb_ertn = 0; csr_eentry = 0; csr_era = 0;
    inst_req_fire = 0; inst_resp_fire = 0; redirect_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flush", flush, 0);
    chk("rst_stall", fetch_stall, 0);
    chk("rst_rvalid", redirect_valid, 0);
    chk("rst_pc", redirect_pc, 0);
    chk("rst_busy", busy, 0);
    resetn = 1;

    // Idle trigger, then back-to-back trigger in the first IDLE cycle
    nxt(); wb_ex = 1; csr_eentry = 32'h1C008000; settle();
    chk("idle_flush_T", flush, 1);
    chk("idle_rv_T", redirect_valid, 0);
    nxt(); redirect_ack = 1; settle();
    chk("idle_flush_T1", flush, 0);
    chk("idle_rv_T1", redirect_valid, 1);
    chk("idle_pc_T1", redirect_pc, 32'h1C008000);
    nxt(); wb_ex = 1; csr_eentry = 32'h1C00C000; settle();
    chk("idle_busy_T2", busy, 0);
    chk("b2b_flush", flush, 1);
    nxt(); redirect_ack = 1; settle();
    chk("b2b_rv", redirect_valid, 1);
    chk("b2b_pc", redirect_pc, 32'h1C00C000);

    // Drain two, with an ignored exception during DRAIN
    nxt(); inst_req_fire = 1;
    nxt(); inst_req_fire = 1;
    nxt(); wb_ertn = 1; csr_era = 32'h1C000100; settle();
    chk("drain_flush_T", flush, 1);
    nxt(); wb_ex = 1; csr_eentry = 32'hDEAD0000; settle();
    chk("drain_ign_flush", flush, 0);
    chk("drain_disc_T1", resp_discard, 1);
    chk("drain_stall_T1", fetch_stall, 1);
    nxt(); settle();
    chk("drain_disc_T2", resp_discard, 1);
    nxt(); inst_resp_fire = 1; settle();
    chk("drain_disc_T3", resp_discard, 1);
    nxt(); settle();
    chk("drain_stall_T4", fetch_stall, 1);
    nxt(); inst_resp_fire = 1; settle();
    chk("drain_disc_T5", resp_discard, 1);
    chk("drain_rv_T5", redirect_valid, 0);
    nxt(); redirect_ack = 1; settle();
    chk("drain_rv_T6", redirect_valid, 1);
    chk("drain_pc_T6", redirect_pc, 32'h1C000100);
    chk("drain_disc_T6", resp_discard, 0);
    nxt(); settle();
    chk("drain_busy_T7", busy, 0);

    // Priority with a request in the trigger cycle, then delayed ack
    nxt(); wb_ex = 1; wb_ertn = 1; inst_req_fire = 1;
    csr_eentry = 32'h1C00A000; csr_era = 32'h1C00B000; settle();
    chk("prio_flush", flush, 1);
    nxt(); settle();
    chk("prio_disc_T1", resp_discard, 1);
    chk("prio_rv_T1", redirect_valid, 0);
    nxt(); inst_resp_fire = 1; settle();
    chk("prio_disc_T2", resp_discard, 1);
    nxt(); settle();
    chk("prio_rv_T3", redirect_valid, 1);
    chk("prio_pc_T3", redirect_pc, 32'h1C00A000);
    nxt(); wb_ex = 1; csr_eentry = 32'h12345678; settle();
    chk("ack_ign_flush", flush, 0);
    chk("ack_rv_T4", redirect_valid, 1);
    chk("ack_pc_T4", redirect_pc, 32'h1C00A000);
    nxt(); settle();
    chk("ack_rv_T5", redirect_valid, 1);
    chk("ack_pc_T5", redirect_pc, 32'h1C00A000);
    nxt(); redirect_ack = 1; settle();
    chk("ack_rv_T6", redirect_valid, 1);
    nxt(); settle();
    chk("ack_busy_T7", busy, 0);

    // Counter limits and spurious response
    nxt(); inst_req_fire = 1;
    nxt(); inst_req_fire = 1; settle();
    chk("cnt1_stall", fetch_stall, 0);
    nxt(); settle();
    chk("cnt2_stall", fetch_stall, 1);
    nxt(); inst_resp_fire = 1;
    nxt(); inst_resp_fire = 1;
    nxt(); inst_resp_fire = 1; settle();
    chk("spur_stall", fetch_stall, 0);
    nxt(); inst_req_fire = 1;
    nxt(); inst_req_fire = 1;
    nxt(); settle();
    chk("refill_stall", fetch_stall, 1);
    nxt(); inst_resp_fire = 1;
    nxt(); inst_resp_fire = 1;
    nxt(); settle();
    chk("empty_stall", fetch_stall, 0);

    // Reset mid-REDIR
    nxt(); wb_ex = 1; csr_eentry = 32'h1C00D000;
    nxt(); settle();
    chk("rr_rv", redirect_valid, 1);
    nxt(); resetn = 0; wb_ex = 1; settle();
    chk("rr_flush", flush, 0);
    chk("rr_stall", fetch_stall, 0);
    chk("rr_disc", resp_discard, 0);
    chk("rr_rv0", redirect_valid, 0);
    chk("rr_pc", redirect_pc, 0);
    chk("rr_busy", busy, 0);
    nxt(); resetn = 1;
    nxt(); settle();
    chk("rr_after_busy", busy, 0);
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/flush_ctrl.md
# flush_ctrl

Exception/ertn flush sequencer between the WB stage, the CSR file and the IF stage's instruction-bus interface. On an exception or `ertn` retiring in WB, it squashes all stages in the same cycle and latches the redirect target (`eentry` or `era`). It then blocks fetch while it drops every instruction-bus response still in flight from the killed path. Only after that does it present the redirect PC to IF.

## Interface
- `MAX_OUTSTANDING`, default 2: maximum in-flight instruction requests, from address accepted to data returned; legal range 1–15.
- `clk` input 1: clock; all state updates on rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `wb_ex` input 1: valid-qualified exception retiring in WB.
- `wb_ertn` input 1: valid-qualified `ertn` retiring in WB.
- `csr_eentry` input 32: exception entry address from the CSR file.
- `csr_era` input 32: exception return address from the CSR file.
- `inst_req_fire` input 1: IF request accepted this cycle (`req & addr_ok`).
- `inst_resp_fire` input 1: instruction data returned this cycle (`data_ok`).
- `redirect_ack` input 1: IF has loaded `redirect_pc` this cycle.
- `flush` output 1: clear the valid bit of IF, ID, EX and MEM this cycle.
- `fetch_stall` output 1: IF must not issue a request this cycle.
- `resp_discard` output 1: IF must drop any response returned this cycle.
- `redirect_valid` output 1: `redirect_pc` is valid; held until ack.
- `redirect_pc` output 32: target PC.
- `busy` output 1: state is not IDLE.

## Operation
- States: IDLE, DRAIN, REDIR.
- Trigger: `trig = (wb_ex | wb_ertn) & (state == IDLE)`.
  - Target on trigger: `csr_eentry` if `wb_ex`, else `csr_era`.
  - If `wb_ex` and `wb_ertn` are both high, `wb_ex` wins.
- Outstanding counter `cnt`:
  - Width is `clog2(MAX_OUTSTANDING+1)`.
  - Updated every cycle in every state: `cnt_next = cnt + inst_req_fire - inst_resp_fire`.
  - Simultaneous request and response leaves `cnt` unchanged.
  - `inst_resp_fire` at `cnt == 0` with no request is ignored; the counter never underflows.
- Fetch stall: `fetch_stall = (state == DRAIN) | (state == REDIR) | (cnt == MAX_OUTSTANDING)`.
- IDLE:
  - `flush = trig`, combinational in the same cycle.
  - On `trig`: latch the target into `redirect_pc`.
  - On `trig`: go to DRAIN if `cnt_next != 0`, else go to REDIR.
  - A response in the trigger cycle still belongs to the old stream. It is delivered normally, since the stage that receives it is flushed that cycle.
- DRAIN:
  - `resp_discard = 1`.
  - Go to REDIR when `cnt_next == 0`.
  - `wb_ex`/`wb_ertn` are ignored (the pipeline is empty) and the latched target is not overwritten.
- REDIR:
  - `redirect_valid = 1`.
  - `redirect_pc` is held stable.
  - On `redirect_ack`: go to IDLE.
  - Triggers are ignored.
- `flush` is asserted only in IDLE on the trigger cycle.
- `busy = (state != IDLE)`.

## Timing
- Reset values, asynchronous on `resetn == 0`:
  - state IDLE, `cnt = 0`, `redirect_pc = 32'h0`.
  - All outputs 0.
- Reset mid-DRAIN or mid-REDIR: return to IDLE immediately, counter cleared, with no redirect issued. The instruction bus is reset at the same time.
- Trigger at cycle T:
  - `flush` is high in T only.
  - With nothing outstanding: `redirect_valid` rises at T+1.
  - With N responses outstanding after T: `redirect_valid` rises the cycle after the Nth response.
- Responses are discarded at T+1 up to and including the cycle of the final drained response.
- `redirect_ack` in the first REDIR cycle gives `redirect_valid` for exactly one cycle; IDLE at the next cycle.
- Back-to-back: a new trigger is accepted in the first IDLE cycle after REDIR.
- `fetch_stall` is combinational from state and `cnt`. The request issued in the trigger cycle itself is counted and later drained.

## Test plan
- Idle trigger:
  - Stimulus: `cnt = 0`, `wb_ex = 1` at T, `csr_eentry = 32'h1C008000`, `redirect_ack` at T+1.
  - Required: `flush` high at T only; `redirect_valid` high at T+1 with `redirect_pc = 32'h1C008000`; `busy` low at T+2.
- Drain two:
  - Stimulus: two requests accepted, no responses, `wb_ertn` at T with `csr_era = 32'h1C000100`; responses at T+3 and T+5.
  - Required: `resp_discard` and `fetch_stall` high T+1..T+5; `redirect_valid` rises at T+6 with `32'h1C000100`.
- Priority and trigger-cycle request:
  - Stimulus: `wb_ex` and `wb_ertn` both high at T, `inst_req_fire = 1` at T, `cnt = 0`.
  - Required: target is `csr_eentry`; state is DRAIN for one response, then REDIR.
- Counter limits:
  - Stimulus: `MAX_OUTSTANDING = 2`, fill to 2 outstanding; also issue a spurious `inst_resp_fire` at `cnt = 0`.
  - Required: `fetch_stall` high at `cnt = 2`; the spurious response leaves `cnt` at 0.
- Ignored triggers and reset:
  - Stimulus: pulse `wb_ex` with a different `csr_eentry` during DRAIN and during REDIR.
  - Required: no `flush`, `redirect_pc` unchanged.
  - Stimulus: assert `resetn = 0` mid-REDIR.
  - Required: all outputs 0 and state IDLE immediately.
- Ack delay:
  - Stimulus: hold `redirect_ack` low for 3 cycles in REDIR.
  - Required: `redirect_valid` and `redirect_pc` stay stable for all 3 cycles; IDLE the cycle after the ack.
